// File: rtl/registros_multipuerto_if.sv
// registros_multipuerto_if: bus bundle between decode, write-back, debug unit and the register file
//   write : i_RegWrite, i_Step, i_RD, i_DatoEscritura
//   read  : i_RS -> o_Read (NREAD ports), i_RegDebug -> o_RegDebug
//   dump  : i_DumpStart, i_DumpAck -> o_DumpValid, o_DumpIdx, o_DumpDato, o_DumpDone
//   status: o_Ready
interface registros_multipuerto_if #(
    parameter int NBITS = 32,
    parameter int REGS  = 5,
    parameter int NREAD = 2
);
    logic                   i_RegWrite;
    logic                   i_Step;
    logic [REGS-1:0]        i_RD;
    logic [NBITS-1:0]       i_DatoEscritura;
    logic [NREAD*REGS-1:0]  i_RS;
    logic [NREAD*NBITS-1:0] o_Read;
    logic [REGS-1:0]        i_RegDebug;
    logic [NBITS-1:0]       o_RegDebug;
    logic                   o_Ready;
    logic                   i_DumpStart;
    logic                   i_DumpAck;
    logic                   o_DumpValid;
    logic [REGS-1:0]        o_DumpIdx;
    logic [NBITS-1:0]       o_DumpDato;
    logic                   o_DumpDone;
    modport master (
        output i_RegWrite, i_Step, i_RD, i_DatoEscritura, i_RS, i_RegDebug, i_DumpStart, i_DumpAck,
        input  o_Read, o_RegDebug, o_Ready, o_DumpValid, o_DumpIdx, o_DumpDato, o_DumpDone
    );
    modport slave (
        input  i_RegWrite, i_Step, i_RD, i_DatoEscritura, i_RS, i_RegDebug, i_DumpStart, i_DumpAck,
        output o_Read, o_RegDebug, o_Ready, o_DumpValid, o_DumpIdx, o_DumpDato, o_DumpDone
    );
endinterface

// File: rtl/registros_multipuerto.sv
// registros_multipuerto: multi-read-port MIPS register file with init sweep and debug dump stream
//   i_clk, i_reset : clock and synchronous active-high reset
//   bus (slave)    : write port, NREAD read ports, debug read port, dump handshake, o_Ready
module registros_multipuerto #(
    parameter int NBITS    = 32,
    parameter int REGS     = 5,
    parameter int CELDAS   = 32,
    parameter int NREAD    = 2,
    parameter int ZERO_R0  = 1,
    parameter int BYPASS   = 1,
    parameter int INIT_IDX = 1
) (
    input logic                  i_clk,
    input logic                  i_reset,
    registros_multipuerto_if.slave bus
);
    localparam logic [1:0] INIT = 2'd0, RUN = 2'd1, DUMP = 2'd2;
    localparam logic [REGS-1:0] LAST = REGS'(CELDAS - 1);
    // sized to the full address space so every address indexes legally; only the first CELDAS are used
    logic [NBITS-1:0] mem_q [2**REGS];
    logic [1:0]       state_q, state_d;
    logic [REGS-1:0]  cnt_q, cnt_d, idx_q, idx_d;
    logic             valid_q, valid_d, done_q, done_d;
    logic             ready, we, mem_en;
    logic [REGS-1:0]  mem_a;
    logic [NBITS-1:0] mem_w;

    assign ready = state_q != INIT;
    // out-of-range writes are dropped; such addresses read 0 anyway, so bypass is unaffected
    assign we = ready && bus.i_RegWrite && bus.i_Step && !(ZERO_R0 != 0 && bus.i_RD == '0)
                && int'(bus.i_RD) < CELDAS;

    function automatic logic [NBITS-1:0] rd(input logic [REGS-1:0] a);
        return (!ready || (ZERO_R0 != 0 && a == '0) || int'(a) >= CELDAS) ? '0 :
               (BYPASS != 0 && we && a == bus.i_RD) ? bus.i_DatoEscritura : mem_q[a];
    endfunction

    always_comb begin
        bus.o_Read = '0;
        for (int p = 0; p < NREAD; p++) bus.o_Read[p*NBITS +: NBITS] = rd(bus.i_RS[p*REGS +: REGS]);
        bus.o_RegDebug = rd(bus.i_RegDebug);
        // the dump shows stored contents only: a same-cycle write appears after the edge
        bus.o_DumpDato = (!ready || (ZERO_R0 != 0 && idx_q == '0)) ? '0 : mem_q[idx_q];
    end

    assign bus.o_Ready     = ready;
    assign bus.o_DumpValid = valid_q;
    assign bus.o_DumpIdx   = idx_q;
    assign bus.o_DumpDone  = done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        mem_en  = we;
        mem_a   = bus.i_RD;
        mem_w   = bus.i_DatoEscritura;
        if (state_q == INIT) begin
            mem_en = 1'b1;
            mem_a  = cnt_q;
            mem_w  = INIT_IDX != 0 ? NBITS'(cnt_q) : '0;
            cnt_d  = cnt_q + REGS'(1);
            if (cnt_q == LAST) state_d = RUN;
        end else if (state_q == RUN && bus.i_DumpStart) begin
            state_d = DUMP;
            idx_d   = '0;
            valid_d = 1'b1;
        end else if (state_q == DUMP && valid_q && bus.i_DumpAck) begin
            if (idx_q == LAST) begin
                state_d = RUN;
                valid_d = 1'b0;
                done_d  = 1'b1;
            end else begin
                idx_d = idx_q + REGS'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= INIT;
            cnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge i_clk)
        if (mem_en && !i_reset) mem_q[mem_a] <= mem_w;
endmodule

// File: tb/tb_registros_multipuerto.sv
// tb_registros_multipuerto: directed table-driven bench for registros_multipuerto
module tb_registros_multipuerto;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int passed = 0;
    logic [31:0] mdl [32];

    always #5 clk = ~clk;

    registros_multipuerto_if #(.NBITS(32), .REGS(5), .NREAD(2)) b0 ();
    registros_multipuerto_if #(.NBITS(32), .REGS(5), .NREAD(2)) b1 ();
    registros_multipuerto_if #(.NBITS(32), .REGS(5), .NREAD(3)) b2 ();

    registros_multipuerto #(.NREAD(2)) u0 (.i_clk(clk), .i_reset(rst), .bus(b0));
    registros_multipuerto #(.NREAD(2), .BYPASS(0)) u1 (.i_clk(clk), .i_reset(rst), .bus(b1));
    registros_multipuerto #(.NREAD(3), .CELDAS(16)) u2 (.i_clk(clk), .i_reset(rst), .bus(b2));

    typedef struct {
        logic [4:0]  rs0, rs1, dbg;
        logic        we, step;
        logic [4:0]  rd;
        logic [31:0] dat, e0, e1, ed;
    } vec_t;
    vec_t vt [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        {b0.i_RegWrite, b0.i_Step, b0.i_RD, b0.i_DatoEscritura, b0.i_RS, b0.i_RegDebug, b0.i_DumpStart, b0.i_DumpAck} = '0;
        {b1.i_RegWrite, b1.i_Step, b1.i_RD, b1.i_DatoEscritura, b1.i_RS, b1.i_RegDebug, b1.i_DumpStart, b1.i_DumpAck} = '0;
        {b2.i_RegWrite, b2.i_Step, b2.i_RD, b2.i_DatoEscritura, b2.i_RS, b2.i_RegDebug, b2.i_DumpStart, b2.i_DumpAck} = '0;
        for (int i = 0; i < 32; i++) mdl[i] = i;
        vt[0]  = '{5'd7,  5'd5,  5'd31, 1'b0, 1'b0, 5'd0,  32'h0,        32'd7,        32'd5,        32'd31};
        vt[1]  = '{5'd9,  5'd0,  5'd9,  1'b1, 1'b0, 5'd9,  32'hDEADBEEF, 32'd9,        32'd0,        32'd9};
        vt[2]  = '{5'd9,  5'd1,  5'd9,  1'b1, 1'b1, 5'd9,  32'hDEADBEEF, 32'hDEADBEEF, 32'd1,        32'hDEADBEEF};
        vt[3]  = '{5'd9,  5'd0,  5'd0,  1'b1, 1'b1, 5'd0,  32'h1234,     32'hDEADBEEF, 32'd0,        32'd0};
        vt[4]  = '{5'd0,  5'd9,  5'd0,  1'b0, 1'b0, 5'd0,  32'h0,        32'd0,        32'hDEADBEEF, 32'd0};
        vt[5]  = '{5'd3,  5'd4,  5'd3,  1'b1, 1'b1, 5'd3,  32'h55,       32'h55,       32'd4,        32'h55};
        vt[6]  = '{5'd3,  5'd31, 5'd4,  1'b0, 1'b0, 5'd0,  32'h0,        32'h55,       32'd31,       32'd4};
        vt[7]  = '{5'd31, 5'd31, 5'd31, 1'b1, 1'b1, 5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vt[8]  = '{5'd31, 5'd30, 5'd31, 1'b0, 1'b0, 5'd0,  32'h0,        32'hFFFFFFFF, 32'd30,       32'hFFFFFFFF};
        vt[9]  = '{5'd12, 5'd13, 5'd12, 1'b1, 1'b1, 5'd12, 32'hC0FFEE,   32'hC0FFEE,   32'd13,       32'hC0FFEE};
        vt[10] = '{5'd12, 5'd2,  5'd12, 1'b0, 1'b0, 5'd0,  32'h0,        32'hC0FFEE,   32'd2,        32'hC0FFEE};
        vt[11] = '{5'd20, 5'd21, 5'd29, 1'b1, 1'b0, 5'd29, 32'h1,        32'd20,       32'd21,       32'd29};

        // reset and init sweep
        tick;
        rst = 1'b0;
        chk("rst_ready", b0.o_Ready, 1'b0);
        chk("rst_valid", b0.o_DumpValid, 1'b0);
        chk("rst_done", b0.o_DumpDone, 1'b0);
        chk("rst_idx", b0.o_DumpIdx, 5'd0);
        for (int k = 1; k <= 32; k++) begin
            b0.i_RegWrite = (k >= 20 && k <= 30);
            b0.i_Step = 1'b1;
            b0.i_RD = 5'd5;
            b0.i_DatoEscritura = 32'hAAAA;
            tick;
            chk($sformatf("sweep_ready0_k%0d", k), b0.o_Ready, k >= 32);
            if (k <= 16) chk($sformatf("sweep_ready2_k%0d", k), b2.o_Ready, k >= 16);
            if (k == 10) begin
                b0.i_RS = {5'd0, 5'd7};
                b0.i_RegDebug = 5'd31;
                b0.i_DumpStart = 1'b1;
                #1;
                chk("init_read0", b0.o_Read[31:0], 32'd0);
                chk("init_dbg", b0.o_RegDebug, 32'd0);
                chk("init_dumpdato", b0.o_DumpDato, 32'd0);
            end
            if (k == 11) begin
                b0.i_DumpStart = 1'b0;
                chk("init_dumpstart_ignored", b0.o_DumpValid, 1'b0);
            end
        end
        b0.i_RegWrite = 1'b0;

        // table-driven read/write vectors on the default instance
        for (int i = 0; i < 12; i++) begin
            b0.i_RS = {vt[i].rs1, vt[i].rs0};
            b0.i_RegDebug = vt[i].dbg;
            b0.i_RegWrite = vt[i].we;
            b0.i_Step = vt[i].step;
            b0.i_RD = vt[i].rd;
            b0.i_DatoEscritura = vt[i].dat;
            #1;
            chk($sformatf("vec%0d_p0", i), b0.o_Read[31:0], vt[i].e0);
            chk($sformatf("vec%0d_p1", i), b0.o_Read[63:32], vt[i].e1);
            chk($sformatf("vec%0d_dbg", i), b0.o_RegDebug, vt[i].ed);
            if (vt[i].we && vt[i].step && vt[i].rd != 5'd0) mdl[vt[i].rd] = vt[i].dat;
            tick;
        end
        b0.i_RegWrite = 1'b0;

        // no bypass: new value visible only after the edge
        b1.i_RS = {5'd4, 5'd3};
        b1.i_RegWrite = 1'b1;
        b1.i_Step = 1'b1;
        b1.i_RD = 5'd3;
        b1.i_DatoEscritura = 32'h55;
        #1;
        chk("nobyp_p0_before", b1.o_Read[31:0], 32'd3);
        chk("nobyp_p1", b1.o_Read[63:32], 32'd4);
        tick;
        b1.i_RegWrite = 1'b0;
        #1;
        chk("nobyp_p0_after", b1.o_Read[31:0], 32'h55);

        // three ports, 16 cells, out-of-range address
        b2.i_RS = {5'd16, 5'd15, 5'd1};
        b2.i_RegDebug = 5'd16;
        #1;
        chk("n3_p0", b2.o_Read[31:0], 32'd1);
        chk("n3_p1", b2.o_Read[63:32], 32'd15);
        chk("n3_p2", b2.o_Read[95:64], 32'd0);
        chk("n3_dbg_oor", b2.o_RegDebug, 32'd0);

        // dump with ack every other cycle
        tick;
        b0.i_DumpStart = 1'b1;
        tick;
        b0.i_DumpStart = 1'b0;
        for (int w = 0; w < 32; w++) begin
            chk($sformatf("dump%0d_valid", w), b0.o_DumpValid, 1'b1);
            chk($sformatf("dump%0d_idx", w), b0.o_DumpIdx, w[4:0]);
            chk($sformatf("dump%0d_dato", w), b0.o_DumpDato, mdl[w]);
            chk($sformatf("dump%0d_done", w), b0.o_DumpDone, 1'b0);
            if (w == 5) b0.i_DumpStart = 1'b1;
            if (w == 20) begin
                b0.i_RegWrite = 1'b1;
                b0.i_Step = 1'b1;
                b0.i_RD = 5'd20;
                b0.i_DatoEscritura = 32'h13579BDF;
                #1;
                chk("dump_same_cycle_old", b0.o_DumpDato, mdl[20]);
                mdl[20] = 32'h13579BDF;
            end
            tick;
            b0.i_DumpStart = 1'b0;
            b0.i_RegWrite = 1'b0;
            chk($sformatf("hold%0d_idx", w), b0.o_DumpIdx, w[4:0]);
            chk($sformatf("hold%0d_valid", w), b0.o_DumpValid, 1'b1);
            chk($sformatf("hold%0d_dato", w), b0.o_DumpDato, mdl[w]);
            b0.i_DumpAck = 1'b1;
            tick;
            b0.i_DumpAck = 1'b0;
        end
        chk("dump_done_pulse", b0.o_DumpDone, 1'b1);
        chk("dump_end_valid", b0.o_DumpValid, 1'b0);
        tick;
        chk("dump_done_once", b0.o_DumpDone, 1'b0);
        chk("dump_after_valid", b0.o_DumpValid, 1'b0);

        // reset in the middle of a dump
        b0.i_DumpStart = 1'b1;
        tick;
        b0.i_DumpStart = 1'b0;
        b0.i_DumpAck = 1'b1;
        repeat (10) tick;
        b0.i_DumpAck = 1'b0;
        chk("mid_idx", b0.o_DumpIdx, 5'd10);
        chk("mid_valid", b0.o_DumpValid, 1'b1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("abort_valid", b0.o_DumpValid, 1'b0);
        chk("abort_done", b0.o_DumpDone, 1'b0);
        chk("abort_ready", b0.o_Ready, 1'b0);
        chk("abort_idx", b0.o_DumpIdx, 5'd0);
        for (int k = 1; k <= 32; k++) begin
            tick;
            if (k == 1) chk("abort_done_next", b0.o_DumpDone, 1'b0);
            if (k >= 31) chk($sformatf("resweep_ready_k%0d", k), b0.o_Ready, k >= 32);
        end
        b0.i_RS = {5'd0, 5'd9};
        b0.i_RegDebug = 5'd20;
        #1;
        chk("resweep_r9", b0.o_Read[31:0], 32'd9);
        chk("resweep_r0", b0.o_Read[63:32], 32'd0);
        chk("resweep_r20", b0.o_RegDebug, 32'd20);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
